ram_lane_mem: RTL and testbench
===============================

# ram_lane_mem

Parametrised lane-organised RAM that replaces the fixed 1024×10 paired-word memory. Each access reads or writes one aligned row of `LANES` words through separate write and read buses, with a request/ready handshake, a registered read with valid flag, per-lane write masks and an optional hardware clear sequencer. It sits between the datapath controller and storage, in the same position as the current paired-word RAM.

## Interface

Parameters:
- `WIDTH`, 10, bits per word.
- `AWIDTH`, 10, word-address width. Depth is 2^AWIDTH words.
- `LANES`, 2, words per row. Must be a power of two, at least 1 and at most 2^AWIDTH.

Ports:
- `clk`, in, 1, clock. All state changes on the rising edge.
- `rst`, in, 1, asynchronous, active-high reset.
- `req`, in, 1, access request.
- `we`, in, 1, 1 for write, 0 for read. Sampled together with `req`.
- `addr`, in, AWIDTH, word address. The row index is `addr >> log2(LANES)`; the low `log2(LANES)` bits are ignored.
- `wdata`, in, LANES*WIDTH, write data. Lane i is `wdata[i*WIDTH +: WIDTH]`.
- `wmask`, in, LANES, per-lane write enable.
- `clr`, in, 1, clear-memory command, pulse or level.
- `ready`, out, 1, a request is accepted this cycle when `req & ready`.
- `rvalid`, out, 1, `rdata` is valid this cycle.
- `rdata`, out, LANES*WIDTH, read data. Lane i is `rdata[i*WIDTH +: WIDTH]`.
- `busy`, out, 1, a clear sequence is in progress.

## Operation

- Storage holds `2^AWIDTH / LANES` rows of `LANES*WIDTH` bits. Memory contents are **not** affected by `rst`.
- The FSM has two states, IDLE and CLEAR. Reset state is IDLE.
- `ready = (state == IDLE) & ~clr`, combinational. `clr` has priority over a same-cycle `req`, which is not accepted.
- **Accepted write:** at the accepting edge, lane i of the addressed row is written with `wdata` lane i when `wmask[i]` is 1. Lanes with a 0 mask bit are unchanged. `wmask == 0` is a legal no-op. `rvalid` is not raised.
- **Accepted read:** at the accepting edge, the whole row is registered into `rdata` and `rvalid` is set. In the next cycle, `rvalid` falls unless another read was accepted. `rdata` holds its last read value until the next read.
- **IDLE & clr:** go to CLEAR with row counter = 0 and `busy` = 1.
- **CLEAR:** each cycle, write all-zero to row[counter] and increment the counter. After writing the last row (`2^AWIDTH/LANES - 1`), return to IDLE; `busy` falls in that same edge.
  - `clr` is ignored while in CLEAR.
  - `req` is not accepted while in CLEAR.
- A read accepted in the cycle before `clr` still produces its `rvalid`, carrying the pre-clear data.

## Timing

- Reset values: `rvalid` = 0, `rdata` = 0, `busy` = 0, state = IDLE, clear counter = 0. `ready` = 1 whenever `clr` = 0.
  - All of these take effect immediately on `rst` assertion, with no clock needed.
- Read latency is one cycle: the request is accepted at edge N, and `rvalid`/`rdata` are valid after edge N, for the cycle up to edge N+1.
- Throughput is one access per cycle, for reads, writes or any mix.
- Read after write: a write accepted at edge N is visible to a read accepted at edge N+1 or later.
- Clear duration: exactly `2^AWIDTH/LANES` cycles of `busy`. With the defaults this is 512 cycles.
- Reset during CLEAR: the block returns to IDLE at once. Rows already written read as zero; the remaining rows are unchanged.
- Reset while a read is outstanding: the pending `rvalid` is dropped.

## Configuration

- `RAM_CLR_EN` defined: the CLEAR state, the row counter and the `clr` handling are compiled in, as described above.
- `RAM_CLR_EN` undefined:
  - the FSM is absent and `clr` is ignored;
  - `busy` is tied to 0 and `ready` is tied to 1;
  - all other behaviour is identical.

## Test plan

Defaults throughout (WIDTH=10, AWIDTH=10, LANES=2), with `RAM_CLR_EN` defined.

- **Full-row write:** write `addr`=10, `wmask`=2'b11, `wdata`={10'd3,10'd5}. Then read `addr`=11 at the next edge. Expect `rvalid` for 1 cycle with `rdata`={10'd3,10'd5}.
- **Masked write:** write `addr`=10, `wmask`=2'b10, `wdata`={10'd7,10'd9}, then read `addr`=10. Expect `rdata`={10'd7,10'd5}.
- **Back-to-back reads:** after writing rows 0..3 with values {2r+1, 2r}, issue reads on `addr` 0, 2, 4, 6 on consecutive edges. Expect `rvalid` high for 4 consecutive cycles with rdata {1,0}, {3,2}, {5,4}, {7,6} in order.
- **Clear:** pulse `clr` for 1 cycle with `req` also high.
  - The request is not accepted.
  - `busy` is high for 512 cycles and `ready` is low for the same window.
  - A following read of `addr`=10 returns {0,0}.
- **Reset during read:** assert `rst` in the cycle after a read is accepted. `rvalid` and `rdata` go to 0 immediately. After release, reading `addr`=10 returns the pre-reset data {10'd7,10'd5}.
- **Reset during clear:** assert `rst` 100 cycles into CLEAR. `busy` goes to 0 immediately and `ready` goes to 1. Row 50 reads {0,0} and row 300 keeps its pre-clear value.

Source files
------------

// File: rtl/ram_lane_mem.sv
// ram_lane_mem: lane-organised RAM, one aligned row of LANES words per access.
// Ports: clk, rst (async, active-high), req/we/addr/wdata/wmask request side,
//   ready handshake, rvalid/rdata registered read, clr command and busy flag.
// Optional macro RAM_CLR_EN compiles in the hardware clear sequencer (clr/busy).
module ram_lane_mem #(
  parameter int WIDTH  = 10,
  parameter int AWIDTH = 10,
  parameter int LANES  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   we,
  input  logic [AWIDTH-1:0]      addr,
  input  logic [LANES*WIDTH-1:0] wdata,
  input  logic [LANES-1:0]       wmask,
  input  logic                   clr,
  output logic                   ready,
  output logic                   rvalid,
  output logic [LANES*WIDTH-1:0] rdata,
  output logic                   busy
);

  localparam int LW   = $clog2(LANES);
  localparam int ROWS = (2 ** AWIDTH) / LANES;
  localparam int RW   = (AWIDTH > LW) ? AWIDTH - LW : 1;
  localparam int DW   = LANES * WIDTH;

  logic [DW-1:0] mem_q [ROWS];

  logic [RW-1:0] row;
  logic          wr_acc;
  logic          rd_acc;
  logic          clr_we;
  logic [RW-1:0] clr_row;

  // Low lane-select bits of the word address are dropped.
  assign row    = RW'(addr >> LW);
  assign wr_acc = req & ready & we;
  assign rd_acc = req & ready & ~we;

`ifdef RAM_CLR_EN
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic          cnt_last;

  assign cnt_last = (cnt_q == RW'(ROWS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (clr) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_last) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy    = (state_q == S_CLEAR);
  // clr wins over a same-cycle request.
  assign ready   = ~busy & ~clr;
  assign clr_we  = busy;
  assign clr_row = cnt_q;
`else
  logic unused_clr;

  assign unused_clr = clr;
  assign busy       = 1'b0;
  assign ready      = 1'b1;
  assign clr_we     = 1'b0;
  assign clr_row    = '0;
`endif

  // Storage is deliberately outside reset.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_row] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < LANES; i++) begin
        if (wmask[i]) begin
          mem_q[row][i*WIDTH +: WIDTH] <= wdata[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  logic          rvalid_q;
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) begin
        rdata_q <= mem_q[row];
      end
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_ram_lane_mem.sv
// tb_ram_lane_mem: directed plus random checks of ram_lane_mem
// against a word-addressed reference array.
module tb_ram_lane_mem;

  localparam int W    = 10;
  localparam int AW   = 10;
  localparam int L    = 2;
  localparam int ROWS = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic          clr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [L*W-1:0] wdata = '0;
  logic [L-1:0]  wmask = '0;
  logic          ready;
  logic          rvalid;
  logic          busy;
  logic [L*W-1:0] rdata;

  ram_lane_mem #(.WIDTH(W), .AWIDTH(AW), .LANES(L)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .wmask (wmask),
    .clr   (clr),
    .ready (ready),
    .rvalid(rvalid),
    .rdata (rdata),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  logic [W-1:0]   mdl [0:1023];
  logic [L*W-1:0] exp_rd;
  int n_run;
  int n_fail;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [L*W-1:0] row_of(input int a);
    int r;
    r = a / L;
    return {mdl[r*L+1], mdl[r*L]};
  endfunction

  // One idle-state access; checks ready before the edge,
  // rvalid/rdata after it.
  task automatic op(input bit rq, input bit w, input int a,
                    input logic [L*W-1:0] d, input logic [L-1:0] m);
    req   = rq;
    we    = w;
    addr  = a[AW-1:0];
    wdata = d;
    wmask = m;
    clr   = 1'b0;
    #1;
    check("ready", ready, 1);
    @(posedge clk);
    if (rq && !w) exp_rd = row_of(a);
    if (rq && w) begin
      for (int i = 0; i < L; i++)
        if (m[i]) mdl[(a/L)*L+i] = d[i*W +: W];
    end
    #1;
    req = 1'b0;
    we  = 1'b0;
    check("rvalid", rvalid, (rq && !w) ? 1 : 0);
    check("rdata", rdata, exp_rd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    n_run  = 0;
    n_fail = 0;
    exp_rd = '0;
    #2;
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", ready, 1);
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < ROWS; r++)
      op(1, 1, r*2, 20'($urandom), 2'b11);

    // Full-row write then read via the odd address of the row.
    op(1, 1, 10, {10'd3, 10'd5}, 2'b11);
    op(1, 0, 11, '0, '0);
    check("full_row", rdata, {10'd3, 10'd5});
    op(0, 0, 0, '0, '0);

    // Upper lane only.
    op(1, 1, 10, {10'd7, 10'd9}, 2'b10);
    op(1, 0, 10, '0, '0);
    check("masked", rdata, {10'd7, 10'd5});
    op(1, 1, 10, {10'd1, 10'd1}, 2'b00);
    op(1, 0, 10, '0, '0);
    check("mask_zero", rdata, {10'd7, 10'd5});

    for (int r = 0; r < 4; r++)
      op(1, 1, r*2, {10'(2*r+1), 10'(2*r)}, 2'b11);
    for (int r = 0; r < 4; r++) begin
      op(1, 0, r*2, '0, '0);
      check("b2b", rdata, {10'(2*r+1), 10'(2*r)});
    end
    op(0, 0, 0, '0, '0);

    // Reset in the cycle after a read is accepted.
    op(1, 0, 10, '0, '0);
    rst = 1'b1;
    #1;
    check("rstrd_rvalid", rvalid, 0);
    check("rstrd_rdata", rdata, 0);
    exp_rd = '0;
    @(negedge clk);
    rst = 1'b0;
    op(1, 0, 10, '0, '0);
    check("rstrd_keep", rdata, {10'd7, 10'd5});

    for (int k = 0; k < 400; k++)
      op($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
         int'($urandom_range(0, 1023)), 20'($urandom),
         2'($urandom));
    op(0, 0, 0, '0, '0);

`ifdef RAM_CLR_EN
    begin
      int  n;
      bit  rdy_bad;
      logic [L*W-1:0] keep;
      // clr with a read request in the same cycle.
      req  = 1'b1;
      we   = 1'b0;
      addr = 10'd10;
      clr  = 1'b1;
      #1;
      check("clr_ready", ready, 0);
      @(posedge clk);
      #1;
      clr = 1'b0;
      req = 1'b0;
      check("clr_nacc", rvalid, 0);
      check("clr_hold", rdata, exp_rd);
      n = 0;
      rdy_bad = 1'b0;
      while (busy === 1'b1 && n < 2000) begin
        if (ready !== 1'b0) rdy_bad = 1'b1;
        n++;
        @(posedge clk);
        #1;
      end
      check("busy_len", n, ROWS);
      check("busy_rdy", rdy_bad, 0);
      check("post_ready", ready, 1);
      for (int i = 0; i < 1024; i++) mdl[i] = '0;
      op(1, 0, 10, '0, '0);
      check("clr_zero", rdata, 0);

      // Reset 100 cycles into a clear.
      op(1, 1, 100, 20'($urandom) | 20'h1, 2'b11);
      op(1, 1, 198, 20'($urandom) | 20'h1, 2'b11);
      op(1, 1, 200, 20'($urandom) | 20'h1, 2'b11);
      op(1, 1, 600, 20'($urandom) | 20'h1, 2'b11);
      keep = row_of(600);
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      check("clr2_busy", busy, 1);
      repeat (100) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rstclr_busy", busy, 0);
      check("rstclr_ready", ready, 1);
      exp_rd = '0;
      for (int i = 0; i < 200; i++) mdl[i] = '0;
      @(negedge clk);
      rst = 1'b0;
      op(1, 0, 100, '0, '0);
      check("row50", rdata, 0);
      op(1, 0, 198, '0, '0);
      op(1, 0, 200, '0, '0);
      op(1, 0, 600, '0, '0);
      check("row300", rdata, keep);
      op(0, 0, 0, '0, '0);
    end
`else
    // clr has no effect without the sequencer.
    req  = 1'b1;
    we   = 1'b0;
    addr = 10'd10;
    clr  = 1'b1;
    #1;
    check("noclr_ready", ready, 1);
    @(posedge clk);
    exp_rd = row_of(10);
    #1;
    clr = 1'b0;
    req = 1'b0;
    check("noclr_rvalid", rvalid, 1);
    check("noclr_rdata", rdata, exp_rd);
    check("noclr_busy", busy, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
